adder_bist_checker: RTL
=======================

ADDER_BIST_CHECKER -- requirements
Module: adder_bist_checker

Interface
REQ-001 Parameter WIDTH, default 4: operand width of the adder under test (1..8).
REQ-002 Parameter SETTLE, default 1: wait cycles between vector apply and response sample (1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle run request; honoured only in IDLE or DONE.
REQ-006 tv_a  output  WIDTH  operand A driven to the adder under test.
REQ-007 tv_b  output  WIDTH  operand B driven to the adder under test.
REQ-008 tv_cin  output  1  carry-in driven to the adder under test.
REQ-009 dut_sum  input  WIDTH  sum returned by the adder under test.
REQ-010 dut_cout  input  1  carry-out returned by the adder under test.
REQ-011 busy  output  1  high in APPLY, WAIT, CHECK.
REQ-012 done  output  1  high in DONE; held until next start or rst.
REQ-013 pass  output  1  high in DONE when err_count is zero; else low.
REQ-014 err_count  output  2*WIDTH+2  count of mismatching vectors in the current/last run.
REQ-015 first_fail_vec  output  2*WIDTH+1  index of first mismatching vector; valid when err_count nonzero.

Function
REQ-016 Vector index vec is 2*WIDTH+1 bits, encoded {a,b,cin} with cin at bit 0; run covers 0 to 2^(2*WIDTH+1)-1 in ascending order.
REQ-017 FSM states IDLE, APPLY, WAIT, CHECK, DONE; all outputs registered.
REQ-018 IDLE/DONE + start -> APPLY; clears vec, err_count, first_fail_vec, done, pass in the same edge.
REQ-019 APPLY: tv_a/tv_b/tv_cin take vec fields; next state WAIT, wait counter loaded with SETTLE.
REQ-020 WAIT: counter decrements each cycle; -> CHECK after exactly SETTLE cycles in WAIT.
REQ-021 CHECK: compare {dut_cout,dut_sum} with tv_a+tv_b+tv_cin computed at WIDTH+1 bits; mismatch increments err_count, captures vec into first_fail_vec only if err_count was zero.
REQ-022 CHECK with vec at all-ones -> DONE; otherwise vec increments, -> APPLY.
REQ-023 Per vector 2+SETTLE cycles; done rises after edge (2+SETTLE)*2^(2*WIDTH+1) following the start-sampling edge.
REQ-024 start during APPLY/WAIT/CHECK ignored; run continues unchanged.
REQ-025 tv_* hold their last value between APPLY phases and in DONE.
REQ-026 err_count never wraps (width holds full vector count).

Reset
REQ-027 rst in any state, including mid-run, -> IDLE next edge; rst dominates start.
REQ-028 Reset values: tv_a=0, tv_b=0, tv_cin=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, vec=0, wait counter=0.

Structure
REQ-029 Package adder_bist_pkg holds the FSM state enum and width helper localparams.
REQ-030 One sub-module adder_bist_ref: combinational golden adder, WIDTH-parameterised, returning WIDTH+1-bit sum.

Verification (WIDTH=4, SETTLE=1, 512 vectors)
REQ-031 Correct behavioural adder, start pulse -> done after 1536 edges, pass=1, err_count=0.
REQ-032 DUT sum[0] stuck-at-0 -> err_count=256, first_fail_vec=1, pass=0.
REQ-033 DUT cout stuck-at-1 -> first_fail_vec=0, err_count=512 minus count of vectors with a+b+cin>=16 (256), i.e. 256.
REQ-034 rst asserted at vector 100 mid-WAIT -> next cycle busy=0, all outputs reset; new start runs full 1536 cycles.
REQ-035 start pulses during busy at cycles 10 and 800 -> no restart, done still at 1536; start in DONE -> clears done, new run.
REQ-036 SETTLE=3 with DUT output delayed 3 cycles -> pass=1; same DUT with SETTLE=1 -> pass=0.

Source files
------------

// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST checker: FSM state encoding and
// width helpers derived from the adder operand width.
package adder_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Settle counter must hold SETTLE values up to 15.
    localparam int WAIT_CNT_W = 4;

    // Vector index {a, b, cin}.
    function automatic int vec_width(input int w);
        return 2 * w + 1;
    endfunction

    // Error counter is one bit wider than the vector index so that a run in
    // which every vector fails still fits without wrapping.
    function automatic int err_width(input int w);
        return 2 * w + 2;
    endfunction

endpackage

// File: rtl/adder_bist_checker_if.sv
// Bus between the BIST checker and the adder under test, plus the run
// control/status signals. The checker uses the master view.
interface adder_bist_checker_if #(
    parameter int WIDTH = 4
);
    import adder_bist_pkg::*;

    logic                        start;
    logic [WIDTH-1:0]            tv_a;
    logic [WIDTH-1:0]            tv_b;
    logic                        tv_cin;
    logic [WIDTH-1:0]            dut_sum;
    logic                        dut_cout;
    logic                        busy;
    logic                        done;
    logic                        pass;
    logic [err_width(WIDTH)-1:0] err_count;
    logic [vec_width(WIDTH)-1:0] first_fail_vec;

    modport master (
        input  start, dut_sum, dut_cout,
        output tv_a, tv_b, tv_cin, busy, done, pass, err_count, first_fail_vec
    );

    modport slave (
        output start, dut_sum, dut_cout,
        input  tv_a, tv_b, tv_cin, busy, done, pass, err_count, first_fail_vec
    );

endinterface

// File: rtl/adder_bist_ref.sv
// Golden combinational adder: WIDTH-bit operands plus carry-in, result
// returned with the carry-out as the top bit.
module adder_bist_ref #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_bist_checker.sv
// Exhaustive BIST for a WIDTH-bit adder: walks every {a, b, cin} vector in
// ascending order, waits SETTLE cycles for the response, compares it against
// a golden adder and reports error count and first failing vector.
module adder_bist_checker
    import adder_bist_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_bist_checker_if.master bus
);

    localparam int VEC_W = vec_width(WIDTH);
    localparam int ERR_W = err_width(WIDTH);
    localparam logic [WAIT_CNT_W-1:0] SETTLE_CNT = WAIT_CNT_W'(SETTLE);

    state_t                  state_r, state_s;
    logic [VEC_W-1:0]        vec_r, vec_s;
    logic [WAIT_CNT_W-1:0]   wait_cnt_r, wait_cnt_s;
    logic [WIDTH-1:0]        tv_a_r, tv_a_s;
    logic [WIDTH-1:0]        tv_b_r, tv_b_s;
    logic                    tv_cin_r, tv_cin_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    pass_r, pass_s;
    logic [ERR_W-1:0]        err_r, err_s;
    logic [VEC_W-1:0]        ffv_r, ffv_s;
    logic [WIDTH:0]          ref_sum_s;
    logic                    mismatch_s;

    // Golden result for the operands currently driven to the adder.
    adder_bist_ref #(.WIDTH(WIDTH)) u_ref (
        .a   (tv_a_r),
        .b   (tv_b_r),
        .cin (tv_cin_r),
        .sum (ref_sum_s)
    );

    assign mismatch_s = ({bus.dut_cout, bus.dut_sum} != ref_sum_s);

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s    = state_r;
        vec_s      = vec_r;
        wait_cnt_s = wait_cnt_r;
        tv_a_s     = tv_a_r;
        tv_b_s     = tv_b_r;
        tv_cin_s   = tv_cin_r;
        done_s     = done_r;
        pass_s     = pass_r;
        err_s      = err_r;
        ffv_s      = ffv_r;
        busy_s     = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_s = ST_APPLY;
                    vec_s   = {VEC_W{1'b0}};
                    err_s   = {ERR_W{1'b0}};
                    ffv_s   = {VEC_W{1'b0}};
                    done_s  = 1'b0;
                    pass_s  = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_APPLY: begin
                tv_a_s     = vec_r[VEC_W-1 -: WIDTH];
                tv_b_s     = vec_r[WIDTH:1];
                tv_cin_s   = vec_r[0];
                wait_cnt_s = SETTLE_CNT;
                state_s    = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter was loaded with SETTLE; leave on its last count.
                if (wait_cnt_r <= WAIT_CNT_W'(1)) begin
                    wait_cnt_s = {WAIT_CNT_W{1'b0}};
                    state_s    = ST_CHECK;
                end else begin
                    wait_cnt_s = wait_cnt_r - WAIT_CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    if (err_r == {ERR_W{1'b0}}) begin
                        ffv_s = vec_r;
                    end else begin
                        ffv_s = ffv_r;
                    end
                    // Saturate defensively; the width already covers all vectors.
                    if (err_r != {ERR_W{1'b1}}) begin
                        err_s = err_r + ERR_W'(1);
                    end else begin
                        err_s = err_r;
                    end
                end else begin
                    err_s = err_r;
                end

                if (&vec_r) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    pass_s  = (err_s == {ERR_W{1'b0}});
                end else begin
                    vec_s   = vec_r + VEC_W'(1);
                    state_s = ST_APPLY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // busy is registered, so it follows the state being entered.
        if ((state_s == ST_APPLY) || (state_s == ST_WAIT) || (state_s == ST_CHECK)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            vec_r      <= {VEC_W{1'b0}};
            wait_cnt_r <= {WAIT_CNT_W{1'b0}};
            tv_a_r     <= {WIDTH{1'b0}};
            tv_b_r     <= {WIDTH{1'b0}};
            tv_cin_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_r      <= {ERR_W{1'b0}};
            ffv_r      <= {VEC_W{1'b0}};
        end else begin
            state_r    <= state_s;
            vec_r      <= vec_s;
            wait_cnt_r <= wait_cnt_s;
            tv_a_r     <= tv_a_s;
            tv_b_r     <= tv_b_s;
            tv_cin_r   <= tv_cin_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            pass_r     <= pass_s;
            err_r      <= err_s;
            ffv_r      <= ffv_s;
        end
    end

    assign bus.tv_a           = tv_a_r;
    assign bus.tv_b           = tv_b_r;
    assign bus.tv_cin         = tv_cin_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.pass           = pass_r;
    assign bus.err_count      = err_r;
    assign bus.first_fail_vec = ffv_r;

endmodule
